// File: rtl/sawim_phase_capture_pkg.sv
// rtl/sawim_phase_capture_pkg.sv - shared types, mode constants and width helper for the SAWIM phase capture engine
package sawim_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Occupancy must represent 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sawim_phase_capture_if.sv
// rtl/sawim_phase_capture_if.sv - control, strobe and drain signals of the phase capture engine
interface sawim_phase_capture_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 16,
    parameter int DEPTH    = 16,
    parameter int OVF_W    = 8
);
    import sawim_capture_pkg::*;

    localparam int LVL_W = level_w(DEPTH);

    logic                         mode_port;
    logic                         arm_port;
    logic                         clear_port;
    logic                         strb_port;
    logic [CHANNELS*DATA_W-1:0]   data_port;
    logic                         rd_ready_port;
    logic [CHANNELS*DATA_W-1:0]   rd_data_port;
    logic [IDX_W-1:0]             rd_index_port;
    logic                         rd_valid_port;
    logic                         busy_port;
    logic                         done_port;
    logic [LVL_W-1:0]             level_port;
    logic [OVF_W-1:0]             overflow_cnt_port;

    modport master (
        output mode_port, arm_port, clear_port, strb_port, data_port, rd_ready_port,
        input  rd_data_port, rd_index_port, rd_valid_port, busy_port, done_port,
               level_port, overflow_cnt_port
    );

    modport slave (
        input  mode_port, arm_port, clear_port, strb_port, data_port, rd_ready_port,
        output rd_data_port, rd_index_port, rd_valid_port, busy_port, done_port,
               level_port, overflow_cnt_port
    );

endinterface

// File: rtl/sawim_phase_capture_fifo.sv
// rtl/sawim_phase_capture_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sawim_sync_fifo
    import sawim_capture_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16,
    parameter int LVL_W = level_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sawim_phase_capture.sv
// rtl/sawim_phase_capture.sv - strobe-edge phase/magnitude capture with frame modes and overflow accounting
module sawim_phase_capture
    import sawim_capture_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64,
    parameter int IDX_W     = 16,
    parameter int OVF_W     = 8
) (
    input  logic                    clk_port,
    input  logic                    reset_port,
    sawim_phase_capture_if.slave    bus
);

    localparam int DW      = CHANNELS * DATA_W;
    localparam int LVL_W   = level_w(DEPTH);
    localparam int FC_W    = $clog2(FRAME_LEN + 1);
    localparam int ENTRY_W = DW + IDX_W;

    state_t             state;
    state_t             state_nxt;
    logic               mode_q;
    logic               strb_prev;
    logic [IDX_W-1:0]   index;
    logic [FC_W-1:0]    frame_cnt;
    logic [OVF_W-1:0]   ovf_cnt;

    logic               strb_edge;
    logic               capture;
    logic               arm_ok;
    logic               pop;
    logic               dropped;
    logic               frame_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [ENTRY_W-1:0] fifo_rd;

    assign strb_edge  = bus.strb_port & ~strb_prev;
    assign capture    = ~bus.clear_port & strb_edge & ((state == ARMED) || (state == CAPTURE));
    assign arm_ok     = ~bus.clear_port & bus.arm_port & ((state == IDLE) || (state == DONE));
    assign pop        = ~fifo_empty & bus.rd_ready_port & ~bus.clear_port;
    assign dropped    = capture & fifo_full & ~pop;
    // The frame counts strobe edges, so a dropped sample still advances it
    assign frame_last = capture & (mode_q == MODE_SINGLE) & (frame_cnt == FC_W'(FRAME_LEN - 1));

    always_ff @(posedge clk_port or posedge reset_port) begin
        if (reset_port) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear_port) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_ok) begin
                        state_nxt = (bus.mode_port == MODE_SINGLE) ? ARMED : CAPTURE;
                    end
                end
                ARMED: begin
                    if (frame_last) begin
                        state_nxt = DONE;
                    end else if (capture) begin
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (frame_last) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy_port = 1'b0;
        bus.done_port = 1'b0;
        case (state)
            ARMED, CAPTURE: bus.busy_port = 1'b1;
            DONE:           bus.done_port = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_port or posedge reset_port) begin
        if (reset_port) begin
            strb_prev <= 1'b0;
            mode_q    <= MODE_CONT;
            index     <= '0;
            frame_cnt <= '0;
            ovf_cnt   <= '0;
        end else begin
            strb_prev <= bus.strb_port;
            if (bus.clear_port) begin
                index     <= '0;
                frame_cnt <= '0;
                ovf_cnt   <= '0;
            end else begin
                if (arm_ok) begin
                    mode_q    <= bus.mode_port;
                    index     <= '0;
                    frame_cnt <= '0;
                end else if (capture) begin
                    index <= index + IDX_W'(1);
                    if (mode_q == MODE_SINGLE) begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
                if (dropped && (ovf_cnt != '1)) begin
                    ovf_cnt <= ovf_cnt + OVF_W'(1);
                end
            end
        end
    end

    sawim_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk_port),
        .rst     (reset_port),
        .flush   (bus.clear_port),
        .push    (capture),
        .pop     (pop),
        .wr_data ({index, bus.data_port}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bus.rd_data_port      = fifo_rd[DW-1:0];
    assign bus.rd_index_port     = fifo_rd[ENTRY_W-1:DW];
    assign bus.rd_valid_port     = ~fifo_empty;
    assign bus.level_port        = fifo_level;
    assign bus.overflow_cnt_port = ovf_cnt;

endmodule

// File: tb/tb_sawim_phase_capture.sv
// tb/tb_sawim_phase_capture.sv - self-checking bench for sawim_phase_capture
module tb_sawim_phase_capture;

    logic clk;
    logic reset;

    sawim_phase_capture_if #(.DATA_W(8), .CHANNELS(4), .IDX_W(16), .DEPTH(16), .OVF_W(8)) bus ();
    sawim_phase_capture_if #(.DATA_W(8), .CHANNELS(4), .IDX_W(16), .DEPTH(16), .OVF_W(2)) bus2 ();

    sawim_phase_capture #(
        .DATA_W(8), .CHANNELS(4), .DEPTH(16), .FRAME_LEN(64), .IDX_W(16), .OVF_W(8)
    ) dut (
        .clk_port   (clk),
        .reset_port (reset),
        .bus        (bus)
    );

    // Narrow overflow counter instance fed with identical stimulus
    sawim_phase_capture #(
        .DATA_W(8), .CHANNELS(4), .DEPTH(16), .FRAME_LEN(64), .IDX_W(16), .OVF_W(2)
    ) dut2 (
        .clk_port   (clk),
        .reset_port (reset),
        .bus        (bus2)
    );

    assign bus2.mode_port     = bus.mode_port;
    assign bus2.arm_port      = bus.arm_port;
    assign bus2.clear_port    = bus.clear_port;
    assign bus2.strb_port     = bus.strb_port;
    assign bus2.data_port     = bus.data_port;
    assign bus2.rd_ready_port = bus.rd_ready_port;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [15:0] idx;
    } vec_t;

    vec_t        vecs [6];
    logic [47:0] sb [$];
    logic [47:0] mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        pre_valid, post_valid, pre_done, post_done, post_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rd_valid_port && bus.rd_ready_port && !bus.clear_port) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got index 0x%0h expected no read", bus.rd_index_port);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", 64'(bus.rd_data_port), 64'(mon_e[47:16]));
                check("rd_index", 64'(bus.rd_index_port), 64'(mon_e[15:0]));
            end
        end
    end

    task automatic to_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) to_cycle();
    endtask

    task automatic arm(input logic m);
        bus.arm_port  = 1'b1;
        bus.mode_port = m;
        to_cycle();
        bus.arm_port  = 1'b0;
    endtask

    task automatic clear();
        bus.clear_port = 1'b1;
        to_cycle();
        bus.clear_port = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] d);
        bus.strb_port = 1'b1;
        bus.data_port = d;
        @(negedge clk);
        pre_valid = bus.rd_valid_port;
        pre_done  = bus.done_port;
        to_cycle();
        bus.strb_port = 1'b0;
        @(negedge clk);
        post_valid = bus.rd_valid_port;
        post_done  = bus.done_port;
        post_busy  = bus.busy_port;
        to_cycle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.rd_valid_port), 0);
        check({tag, "_busy"}, 64'(bus.busy_port), 0);
        check({tag, "_done"}, 64'(bus.done_port), 0);
        check({tag, "_level"}, 64'(bus.level_port), 0);
        check({tag, "_ovf"}, 64'(bus.overflow_cnt_port), 0);
        check({tag, "_data"}, 64'(bus.rd_data_port), 0);
        check({tag, "_index"}, 64'(bus.rd_index_port), 0);
    endtask

    initial begin
        logic [31:0] d;

        vecs[0] = '{32'h0403_0201, 16'd0};
        vecs[1] = '{32'h0807_0605, 16'd1};
        vecs[2] = '{32'h0C0B_0A09, 16'd2};
        vecs[3] = '{32'hFFFF_FFFF, 16'd3};
        vecs[4] = '{32'h0000_0000, 16'd4};
        vecs[5] = '{32'hA5A5_5A5A, 16'd5};

        reset             = 1'b1;
        bus.mode_port     = 1'b0;
        bus.arm_port      = 1'b0;
        bus.clear_port    = 1'b0;
        bus.strb_port     = 1'b0;
        bus.data_port     = '0;
        bus.rd_ready_port = 1'b0;

        #2;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Continuous basic
        bus.rd_ready_port = 1'b1;
        arm(1'b0);
        @(negedge clk);
        check("cont_busy", 64'(bus.busy_port), 1);
        to_cycle();
        for (int i = 0; i < 6; i++) begin
            sb.push_back({vecs[i].data, vecs[i].idx});
            pulse(vecs[i].data);
        end
        cycles(2);
        @(negedge clk);
        check("cont_drained", 64'(sb.size()), 0);
        check("cont_ovf", 64'(bus.overflow_cnt_port), 0);
        check("cont_level", 64'(bus.level_port), 0);
        to_cycle();

        // Single-shot frame of 64 out of 70 edges
        clear();
        arm(1'b1);
        @(negedge clk);
        check("armed_busy", 64'(bus.busy_port), 1);
        check("armed_done", 64'(bus.done_port), 0);
        to_cycle();
        for (int i = 0; i < 70; i++) begin
            d = $urandom;
            if (i < 64) sb.push_back({d, 16'(i)});
            pulse(d);
            if (i == 63) begin
                check("frame_pre_done", 64'(pre_done), 0);
                check("frame_post_done", 64'(post_done), 1);
                check("frame_post_busy", 64'(post_busy), 0);
            end
        end
        cycles(2);
        @(negedge clk);
        check("frame_drained", 64'(sb.size()), 0);
        check("frame_done_held", 64'(bus.done_port), 1);
        check("frame_level", 64'(bus.level_port), 0);
        to_cycle();

        // Overflow with consumer stalled
        clear();
        bus.rd_ready_port = 1'b0;
        arm(1'b0);
        for (int i = 0; i < 20; i++) begin
            d = 32'hA000_0000 + 32'(i);
            if (i < 16) sb.push_back({d, 16'(i)});
            pulse(d);
            if (i == 0) begin
                check("latency_pre_valid", 64'(pre_valid), 0);
                check("latency_post_valid", 64'(post_valid), 1);
            end
        end
        @(negedge clk);
        check("ovf_level", 64'(bus.level_port), 16);
        check("ovf_count", 64'(bus.overflow_cnt_port), 4);
        check("ovf2_count", 64'(bus2.overflow_cnt_port), 3);
        to_cycle();
        for (int i = 20; i < 30; i++) pulse(32'hB000_0000 + 32'(i));
        @(negedge clk);
        check("ovf_count_more", 64'(bus.overflow_cnt_port), 14);
        check("ovf2_saturated", 64'(bus2.overflow_cnt_port), 3);
        to_cycle();
        bus.rd_ready_port = 1'b1;
        cycles(20);
        @(negedge clk);
        check("ovf_drained", 64'(sb.size()), 0);
        check("ovf_level_empty", 64'(bus.level_port), 0);
        to_cycle();

        // Full FIFO with a pop in the same cycle as the edge
        bus.rd_ready_port = 1'b0;
        for (int i = 30; i < 46; i++) begin
            d = 32'hC000_0000 + 32'(i);
            sb.push_back({d, 16'(i)});
            pulse(d);
        end
        bus.rd_ready_port = 1'b1;
        bus.strb_port     = 1'b1;
        bus.data_port     = 32'hDEAD_BEEF;
        sb.push_back({32'hDEAD_BEEF, 16'd46});
        to_cycle();
        bus.rd_ready_port = 1'b0;
        bus.strb_port     = 1'b0;
        @(negedge clk);
        check("fullpop_level", 64'(bus.level_port), 16);
        check("fullpop_ovf", 64'(bus.overflow_cnt_port), 14);
        to_cycle();
        bus.rd_ready_port = 1'b1;
        cycles(20);
        @(negedge clk);
        check("fullpop_drained", 64'(sb.size()), 0);
        to_cycle();

        // Clear beats arm and edge in the same cycle
        bus.rd_ready_port = 1'b0;
        bus.clear_port    = 1'b1;
        bus.arm_port      = 1'b1;
        bus.strb_port     = 1'b1;
        bus.data_port     = 32'h1111_1111;
        to_cycle();
        bus.clear_port = 1'b0;
        bus.arm_port   = 1'b0;
        @(negedge clk);
        check("prio_busy", 64'(bus.busy_port), 0);
        check("prio_level", 64'(bus.level_port), 0);
        check("prio_ovf", 64'(bus.overflow_cnt_port), 0);
        check("prio_ovf2", 64'(bus2.overflow_cnt_port), 0);
        to_cycle();
        bus.strb_port = 1'b0;
        cycles(2);

        // Strobe held high yields one capture; arm during capture is ignored
        arm(1'b0);
        bus.strb_port = 1'b1;
        bus.data_port = 32'h2222_2222;
        sb.push_back({32'h2222_2222, 16'd0});
        cycles(10);
        bus.strb_port = 1'b0;
        @(negedge clk);
        check("held_level", 64'(bus.level_port), 1);
        to_cycle();
        arm(1'b1);
        sb.push_back({32'h3333_3333, 16'd1});
        pulse(32'h3333_3333);
        @(negedge clk);
        check("rearm_level", 64'(bus.level_port), 2);
        check("rearm_busy", 64'(bus.busy_port), 1);
        check("rearm_done", 64'(bus.done_port), 0);
        to_cycle();
        bus.rd_ready_port = 1'b1;
        cycles(4);
        @(negedge clk);
        check("rearm_drained", 64'(sb.size()), 0);
        to_cycle();

        // Asynchronous reset in the middle of a frame
        bus.rd_ready_port = 1'b0;
        clear();
        arm(1'b1);
        for (int i = 0; i < 5; i++) pulse(32'h4400_0001 + 32'(i));
        @(negedge clk);
        check("mid_level", 64'(bus.level_port), 5);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 64'(bus.busy_port), 0);
        check("post_reset_done", 64'(bus.done_port), 0);
        to_cycle();
        pulse(32'h5555_5555);
        @(negedge clk);
        check("idle_no_capture", 64'(bus.level_port), 0);
        check("sb_final", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
